fc_layer_sequencer: RTL and testbench

//  Control FSM that sequences one fully-connected layer datapath (x-vector RAM, weight ROM, P MAC lanes, ReLU).

---
 rtl/fc_pkg.sv | 19 +
 rtl/fc_seq_counter.sv | 41 ++++
 rtl/fc_layer_sequencer.sv | 162 ++++++++++++++++
 tb/tb_fc_layer_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully-connected layer sequencer.
package fc_pkg;

    // Layer flow: fill x RAM, clear accumulators, issue N MACs, let the
    // last product land, then hand the results downstream.
    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        CLEAR = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } fc_state_t;

    // Width of a counter/select covering n values; never narrower than 1 bit.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_seq_counter.sv
// Modulo-MAX up-counter with enable, terminal flag and synchronous clear.
module fc_seq_counter
    import fc_pkg::*;
#(
    parameter int MAX = 4,
    parameter int W   = sel_w(MAX)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         last
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign cnt  = cnt_q;
    assign last = (cnt_q == W'(MAX - 1));

    // Clear wins over counting; the terminal value wraps back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = last ? '0 : cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fc_layer_sequencer.sv
// Control FSM for one fully-connected layer: loads the x vector, runs the
// P-lane MAC datapath group by group and streams results downstream.
module fc_layer_sequencer
    import fc_pkg::*;
#(
    parameter int M = 4,
    parameter int N = 8,
    parameter int T = 16,
    parameter int P = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      input_valid,
    output logic                      input_ready,
    input  logic                      output_ready,
    output logic                      output_valid,
    output logic [sel_w(N)-1:0]       addr_x,
    output logic                      wr_en_x,
    output logic [sel_w(M*N/P)-1:0]   addr_w,
    output logic                      wr_en_w,
    output logic                      clear_acc,
    output logic                      en_acc,
    output logic [sel_w(P)-1:0]       f_sel,
    output logic                      layer_done
);

    localparam int G   = M / P;
    localparam int KW  = sel_w(N);
    localparam int GW  = sel_w(G);
    localparam int LW  = sel_w(P);
    localparam int AWW = sel_w(M * N / P);

    // Catch unusable parameter sets at elaboration.
    if ((M % P) != 0 || N < 2 || T < 1) begin : g_bad_params
        $error("fc_layer_sequencer: need M %% P == 0, N >= 2, T >= 1");
    end

    fc_state_t state_q, state_d;
    logic      en_acc_q, en_acc_d;
    logic      layer_done_q, layer_done_d;

    logic [KW-1:0]  k_cnt;
    logic [GW-1:0]  g_cnt;
    logic [LW-1:0]  lane_cnt;
    logic           k_last, g_last, lane_last;
    logic           accept_in, out_acc, issue_valid;
    logic           g_step;
    logic [AWW-1:0] aw_cur;

    // Weight row base for the current group plus the element index.
    assign aw_cur = AWW'(g_cnt) * AWW'(N) + AWW'(k_cnt);

    // k walks the input vector in LOAD and the MAC issue slots.
    fc_seq_counter #(.MAX(N), .W(KW)) u_k (
        .clk   (clk),
        .rst_n (reset),
        .en    (accept_in | issue_valid),
        .clr   (1'b0),
        .cnt   (k_cnt),
        .last  (k_last)
    );

    // g advances after the last lane of a group is accepted; cleared at layer end.
    assign g_step = out_acc & lane_last;

    fc_seq_counter #(.MAX(G), .W(GW)) u_g (
        .clk   (clk),
        .rst_n (reset),
        .en    (g_step & ~g_last),
        .clr   (g_step & g_last),
        .cnt   (g_cnt),
        .last  (g_last)
    );

    // lane selects which accumulator is presented downstream.
    fc_seq_counter #(.MAX(P), .W(LW)) u_lane (
        .clk   (clk),
        .rst_n (reset),
        .en    (out_acc),
        .clr   (1'b0),
        .cnt   (lane_cnt),
        .last  (lane_last)
    );

    // Next state and datapath controls; outputs forced low while reset is held.
    always_comb begin
        state_d      = state_q;
        input_ready  = 1'b0;
        wr_en_x      = 1'b0;
        addr_x       = '0;
        addr_w       = '0;
        clear_acc    = 1'b0;
        output_valid = 1'b0;
        f_sel        = '0;
        issue_valid  = 1'b0;
        accept_in    = 1'b0;
        out_acc      = 1'b0;

        case (state_q)
            LOAD: begin
                input_ready = 1'b1;
                wr_en_x     = input_valid;
                addr_x      = k_cnt;
                accept_in   = input_valid;
                if (input_valid && k_last) state_d = CLEAR;
            end
            CLEAR: begin
                clear_acc = 1'b1;
                state_d   = MAC;
            end
            MAC: begin
                addr_x      = k_cnt;
                addr_w      = aw_cur;
                issue_valid = 1'b1;
                if (k_last) state_d = DRAIN;
            end
            DRAIN: begin
                // Last product is still in flight through the registered reads.
                state_d = OUT;
            end
            OUT: begin
                output_valid = 1'b1;
                f_sel        = lane_cnt;
                out_acc      = output_ready;
                if (output_ready && lane_last) state_d = g_last ? LOAD : CLEAR;
            end
            default: state_d = LOAD;
        endcase

        // Registered reads mean the product of this issue arrives next cycle.
        en_acc_d     = issue_valid;
        layer_done_d = g_step & g_last;

        if (!reset) begin
            input_ready  = 1'b0;
            wr_en_x      = 1'b0;
            addr_x       = '0;
            addr_w       = '0;
            clear_acc    = 1'b0;
            output_valid = 1'b0;
            f_sel        = '0;
        end
    end

    assign wr_en_w    = 1'b0;
    assign en_acc     = en_acc_q;
    assign layer_done = layer_done_q;

    // State, accumulate strobe delay and done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= LOAD;
            en_acc_q     <= 1'b0;
            layer_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            en_acc_q     <= en_acc_d;
            layer_done_q <= layer_done_d;
        end
    end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Bench for fc_layer_sequencer: scoreboard of issued weight addresses and
// output lane selects, plus latency, handshake and reset checks.
module tb_fc_layer_sequencer;

    localparam int M = 4;
    localparam int N = 8;
    localparam int P = 1;
    localparam int G = M / P;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic input_valid = 1'b0;
    logic output_ready = 1'b0;
    logic input_ready, output_valid, wr_en_x, wr_en_w, clear_acc, en_acc, layer_done;
    logic [2:0] addr_x;
    logic [4:0] addr_w;
    logic [0:0] f_sel;

    // P=2 instance
    logic i2_valid = 1'b0;
    logic o2_ready = 1'b0;
    logic i2_ready, o2_valid, wx2, ww2, ca2, ea2, ld2;
    logic [2:0] ax2;
    logic [3:0] aw2;
    logic [0:0] fs2;

    int checks = 0;
    int errors = 0;
    int aw_q[$];
    int sel_q[$];
    int prev_aw = 0;
    int n_done = 0;

    always #5 clk = ~clk;

    fc_layer_sequencer #(.M(M), .N(N), .T(16), .P(P)) dut (
        .clk(clk), .reset(reset),
        .input_valid(input_valid), .input_ready(input_ready),
        .output_ready(output_ready), .output_valid(output_valid),
        .addr_x(addr_x), .wr_en_x(wr_en_x), .addr_w(addr_w), .wr_en_w(wr_en_w),
        .clear_acc(clear_acc), .en_acc(en_acc), .f_sel(f_sel), .layer_done(layer_done)
    );

    fc_layer_sequencer #(.M(4), .N(8), .T(16), .P(2)) dut2 (
        .clk(clk), .reset(reset),
        .input_valid(i2_valid), .input_ready(i2_ready),
        .output_ready(o2_ready), .output_valid(o2_valid),
        .addr_x(ax2), .wr_en_x(wx2), .addr_w(aw2), .wr_en_w(ww2),
        .clear_acc(ca2), .en_acc(ea2), .f_sel(fs2), .layer_done(ld2)
    );

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    function automatic int all_outs();
        return int'({input_ready, output_valid, wr_en_x, wr_en_w, clear_acc,
                     en_acc, layer_done, addr_x, addr_w, f_sel});
    endfunction

    // Scoreboard: en_acc marks the product of last cycle's issue address.
    always @(negedge clk) begin
        if (reset) begin
            if (en_acc) begin
                if (aw_q.size() == 0) chk("aw_unexpected", prev_aw, -1);
                else                  chk("addr_w", prev_aw, aw_q.pop_front());
            end
            if (output_valid && output_ready) begin
                if (sel_q.size() == 0) chk("out_unexpected", int'(f_sel), -1);
                else                   chk("f_sel", int'(f_sel), sel_q.pop_front());
            end
            if (layer_done) n_done++;
        end
        prev_aw = int'(addr_w);
    end

    // Push a layer's expectations, then stream N inputs (optional one-cycle gap).
    task automatic send_vector(input int gap_at);
        int  i;
        bit  gapped;
        i = 0;
        gapped = 1'b0;
        for (int g = 0; g < G; g++) begin
            for (int k = 0; k < N; k++) aw_q.push_back(g * N + k);
            for (int l = 0; l < P; l++) sel_q.push_back(l);
        end
        while (i < N) begin
            @(posedge clk); #1;
            if (i == gap_at && !gapped) begin
                gapped = 1'b1;
                input_valid = 1'b0;
                @(negedge clk);
                chk("gap_wr_en_x", int'(wr_en_x), 0);
                chk("gap_addr_x", int'(addr_x), i);
                continue;
            end
            input_valid = 1'b1;
            @(negedge clk);
            chk("wr_en_x", int'(wr_en_x), 1);
            chk("addr_x", int'(addr_x), i);
            i++;
        end
        @(posedge clk); #1;
        input_valid = 1'b0;
        @(negedge clk);
        chk("in_ready_busy", int'(input_ready), 0);
        chk("clear_acc", int'(clear_acc), 1);
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!output_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (!output_valid) chk("out_timeout", 0, 1);
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        while (!layer_done && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        if (!layer_done) chk(tag, 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int acc2;
        int max_aw2;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_outs", all_outs(), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", int'(input_ready), 1);
        chk("rst_out_valid", int'(output_valid), 0);

        // Layer A: input gap, held output, per-group latency
        send_vector(3);
        for (int g = 0; g < G; g++) begin
            wait_out(cyc);
            chk("out_latency", cyc, N + 2);
            if (g == 0) begin
                repeat (5) begin
                    @(posedge clk); #1;
                    @(negedge clk);
                    chk("hold_valid", int'(output_valid), 1);
                end
            end
            @(posedge clk); #1;
            output_ready = 1'b1;
            @(negedge clk);
            @(posedge clk); #1;
            output_ready = 1'b0;
            @(negedge clk);
            if (g < G - 1) begin
                chk("clear_next", int'(clear_acc), 1);
            end else begin
                chk("layer_done", int'(layer_done), 1);
                chk("ready_after", int'(input_ready), 1);
            end
        end
        @(negedge clk);
        chk("layer_done_pulse", int'(layer_done), 0);
        #1;
        chk("aw_q_empty_a", aw_q.size(), 0);
        chk("sel_q_empty_a", sel_q.size(), 0);
        chk("n_done_a", n_done, 1);

        // Layer B: output_ready already high when OUT is entered
        output_ready = 1'b1;
        send_vector(-1);
        wait_done("done_timeout_b", cyc);
        chk("layer_b_cycles", cyc, G * (N + 3));
        @(posedge clk); #1;
        output_ready = 1'b0;
        @(negedge clk); #1;
        chk("n_done_b", n_done, 2);
        chk("aw_q_empty_b", aw_q.size(), 0);

        // Reset in the middle of group 0 MAC
        send_vector(-1);
        cyc = 0;
        while (addr_w != 5'd5 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("saw_addr_w5", int'(addr_w), 5);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_outs", all_outs(), 0);
        aw_q.delete();
        sel_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", int'(input_ready), 1);
        output_ready = 1'b1;
        send_vector(-1);
        wait_done("done_timeout_c", cyc);
        chk("layer_c_cycles", cyc, G * (N + 3));
        @(posedge clk); #1;
        output_ready = 1'b0;
        @(negedge clk); #1;
        chk("n_done_c", n_done, 3);
        chk("aw_q_empty_c", aw_q.size(), 0);
        chk("sel_q_empty_c", sel_q.size(), 0);

        // P=2: two lanes per group, two groups
        o2_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            @(posedge clk); #1;
            i2_valid = 1'b1;
        end
        @(posedge clk); #1;
        i2_valid = 1'b0;
        acc2 = 0;
        max_aw2 = 0;
        cyc = 0;
        while (!ld2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (int'(aw2) > max_aw2) max_aw2 = int'(aw2);
            if (o2_valid && o2_ready) begin
                chk("p2_f_sel", int'(fs2), acc2 % 2);
                acc2++;
            end
        end
        chk("p2_done", int'(ld2), 1);
        chk("p2_outputs", acc2, 4);
        chk("p2_max_addr_w", max_aw2, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
